// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - 2x2 window origin scheduler for the convolution image memory
// Optional stall counter output enabled by defining CONV_WIN_SCHED_STALL_CNT_EN.
module conv_window_scheduler #(
    parameter int N_C    = 5,
    parameter int N_R    = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 4,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_row,
    output logic [ADDR_W-1:0] mem_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int R_MAX = ((N_R - 2) / STRIDE) * STRIDE;
    localparam int C_MAX = ((N_C - 2) / STRIDE) * STRIDE;
    localparam logic [ADDR_W-1:0] R_MAX_A  = R_MAX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] C_MAX_A  = C_MAX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STRIDE_A = STRIDE[ADDR_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             issue;
    logic             accept;
    logic             last_issue;
    logic [IDX_W-1:0] idx_cnt;

    assign accept     = out_valid && out_ready;
    assign last_issue = (mem_row == R_MAX_A) && (mem_col == C_MAX_A);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                // A held window blocks the next read so memory data stays stable.
                issue = !out_valid || out_ready;
                if (issue && last_issue) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (accept && out_last) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        mem_en = issue;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_row   <= '0;
            mem_col   <= '0;
            idx_cnt   <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == S_DONE);
            if (state == S_IDLE && start) begin
                mem_row <= '0;
                mem_col <= '0;
                idx_cnt <= '0;
            end
            if (issue) begin
                out_valid <= 1'b1;
                out_row   <= mem_row;
                out_col   <= mem_col;
                out_idx   <= idx_cnt;
                out_last  <= last_issue;
                idx_cnt   <= idx_cnt + IDX_W'(1);
                // Origins are always multiples of STRIDE, so equality marks the wrap point.
                if (mem_col == C_MAX_A) begin
                    mem_col <= '0;
                    mem_row <= (mem_row == R_MAX_A) ? '0 : mem_row + STRIDE_A;
                end else begin
                    mem_col <= mem_col + STRIDE_A;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WIN_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - self-checking bench for conv_window_scheduler
module tb_conv_window_scheduler;

    localparam int AW = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, out_ready;
    logic          mem_en, out_valid, out_last, busy, done;
    logic [AW-1:0] mem_row, mem_col, out_row, out_col;
    logic [IW-1:0] out_idx;

    logic          s2_start, s2_ready;
    logic          s2_mem_en, s2_valid, s2_last, s2_busy, s2_done;
    logic [AW-1:0] s2_mem_row, s2_mem_col, s2_row, s2_col;
    logic [IW-1:0] s2_idx;

`ifdef CONV_WIN_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt, s2_stall_cnt;
`endif

    conv_window_scheduler #(.N_C(5), .N_R(3), .STRIDE(1), .ADDR_W(AW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_en(mem_en), .mem_row(mem_row), .mem_col(mem_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    conv_window_scheduler #(.N_C(5), .N_R(5), .STRIDE(2), .ADDR_W(AW), .IDX_W(IW)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start),
        .mem_en(s2_mem_en), .mem_row(s2_mem_row), .mem_col(s2_mem_col),
        .out_valid(s2_valid), .out_ready(s2_ready),
        .out_row(s2_row), .out_col(s2_col), .out_idx(s2_idx), .out_last(s2_last),
        .busy(s2_busy), .done(s2_done)
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
        , .stall_cnt(s2_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_r[$];
    int exp_c[$];

    // Every origin where a 2x2 window still fits inside the image, raster order.
    function automatic void build_windows(input int nr, input int nc, input int s);
        exp_r.delete();
        exp_c.delete();
        for (int r = 0; r + 2 <= nr; r += s)
            for (int c = 0; c + 2 <= nc; c += s) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            1:       return !(cyc >= 3 && cyc <= 5);
            2:       return (cyc % 2) == 0;
            3:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_scan(input int mode, input int restart_cyc, output int done_cyc, output int stalls);
        int w, k, j, first_valid, last_acc;
        logic prev_stall;
        logic [AW-1:0] pr_row, pr_col;
        logic [IW-1:0] pr_idx;
        logic pr_last;
        w = exp_r.size();
        k = 0; j = 0; first_valid = -1; last_acc = -1; done_cyc = -1; stalls = 0;
        prev_stall = 1'b0; pr_row = '0; pr_col = '0; pr_idx = '0; pr_last = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_before_start: got %b want 0", busy);
        end
        for (int cyc = 1; cyc < 120; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            out_ready = ready_for(mode, cyc);
            #1;
            if (mem_en) begin
                checks++;
                if (j >= w || int'(mem_row) != exp_r[j] || int'(mem_col) != exp_c[j]) begin
                    errors++;
                    $display("FAIL mem_addr cyc %0d issue %0d: got (%0d,%0d) want (%0d,%0d)", cyc, j,
                             mem_row, mem_col, (j < w) ? exp_r[j] : -1, (j < w) ? exp_c[j] : -1);
                end
                j++;
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL stall_mem_en cyc %0d: got %b want 0", cyc, mem_en);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== pr_row || out_col !== pr_col ||
                    out_idx !== pr_idx || out_last !== pr_last) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: got v%b (%0d,%0d) idx %0d want v1 (%0d,%0d) idx %0d",
                             cyc, out_valid, out_row, out_col, out_idx, pr_row, pr_col, pr_idx);
                end
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                checks++;
                if (k >= w || int'(out_row) != exp_r[k] || int'(out_col) != exp_c[k] ||
                    int'(out_idx) != k || out_last !== (k == w - 1)) begin
                    errors++;
                    $display("FAIL window cyc %0d: got (%0d,%0d) idx %0d last %b want (%0d,%0d) idx %0d last %b",
                             cyc, out_row, out_col, out_idx, out_last,
                             (k < w) ? exp_r[k] : -1, (k < w) ? exp_c[k] : -1, k, (k == w - 1));
                end
                k++;
                if (k == w) last_acc = cyc;
            end
            if (done) begin
                checks++;
                if (done_cyc >= 0 || last_acc < 0 || cyc != last_acc + 1) begin
                    errors++;
                    $display("FAIL done_timing: got cyc %0d want %0d", cyc, last_acc + 1);
                end
                if (done_cyc < 0) done_cyc = cyc;
            end
            checks++;
            if (busy !== (done_cyc < 0 || done_cyc == cyc)) begin
                errors++;
                $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, (done_cyc < 0 || done_cyc == cyc));
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stalls++;
            pr_row = out_row; pr_col = out_col; pr_idx = out_idx; pr_last = out_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
        end
        checks++;
        if (first_valid != 2 || k != w || j != w || done_cyc < 0) begin
            errors++;
            $display("FAIL scan_summary: got first_valid %0d accepted %0d issued %0d done %0d want 2 %0d %0d >=0",
                     first_valid, k, j, done_cyc, w, w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        s2_start = 1'b0; s2_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_row, mem_col, out_valid, out_row, out_col, out_idx, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got en%b (%0d,%0d) v%b (%0d,%0d) idx%0d l%b b%b d%b want all 0",
                     mem_en, mem_row, mem_col, out_valid, out_row, out_col, out_idx, out_last, busy, done);
        end
    endtask

    task automatic test_basic();
        int dc, st;
        build_windows(3, 5, 1);
        run_scan(0, -1, dc, st);
        checks++;
        if (dc != 10) begin
            errors++; $display("FAIL basic_done_cycle: got %0d want 10", dc);
        end
    endtask

    task automatic test_backpressure();
        int dc, st;
        build_windows(3, 5, 1);
        run_scan(1, -1, dc, st);
        checks++;
        if (dc != 13 || st != 3) begin
            errors++; $display("FAIL backpressure: got done %0d stalls %0d want 13 3", dc, st);
        end
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_restart_ignored();
        int dc, st;
        build_windows(3, 5, 1);
        run_scan(0, 4, dc, st);
        checks++;
        if (dc != 10) begin
            errors++; $display("FAIL restart_done_cycle: got %0d want 10", dc);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dc, st;
        build_windows(3, 5, 1);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 5) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_row, mem_col, out_valid, out_row, out_col, out_idx, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: got en%b (%0d,%0d) v%b (%0d,%0d) idx%0d l%b b%b d%b want all 0",
                     mem_en, mem_row, mem_col, out_valid, out_row, out_col, out_idx, out_last, busy, done);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_abort: got done %b busy %b valid %b want 0 0 0", done, busy, out_valid);
            end
        end
        run_scan(0, -1, dc, st);
        checks++;
        if (dc != 10) begin
            errors++; $display("FAIL rescan_done_cycle: got %0d want 10", dc);
        end
    endtask

    task automatic test_alternating();
        int dc, st;
        build_windows(3, 5, 1);
        run_scan(2, -1, dc, st);
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
        checks++;
        if (int'(stall_cnt) != st) begin
            errors++; $display("FAIL alt_stall_cnt: got %0d want %0d", stall_cnt, st);
        end
`endif
    endtask

    task automatic test_random();
        int dc, st;
        build_windows(3, 5, 1);
        for (int n = 0; n < 4; n++) begin
            run_scan(3, -1, dc, st);
`ifdef CONV_WIN_SCHED_STALL_CNT_EN
            checks++;
            if (int'(stall_cnt) != st) begin
                errors++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, st);
            end
`endif
        end
    endtask

    task automatic test_stride2();
        int w, k, first_valid, done_cyc;
        build_windows(5, 5, 2);
        w = exp_r.size();
        k = 0; first_valid = -1; done_cyc = -1;
        @(negedge clk);
        s2_start = 1'b1; s2_ready = 1'b1;
        for (int cyc = 1; cyc < 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            s2_start = 1'b0;
            #1;
            if (s2_valid && first_valid < 0) first_valid = cyc;
            if (s2_valid && s2_ready) begin
                checks++;
                if (k >= w || int'(s2_row) != exp_r[k] || int'(s2_col) != exp_c[k] ||
                    int'(s2_idx) != k || s2_last !== (k == w - 1)) begin
                    errors++;
                    $display("FAIL stride2_window: got (%0d,%0d) idx %0d last %b want (%0d,%0d) idx %0d last %b",
                             s2_row, s2_col, s2_idx, s2_last,
                             (k < w) ? exp_r[k] : -1, (k < w) ? exp_c[k] : -1, k, (k == w - 1));
                end
                k++;
            end
            if (s2_done) done_cyc = cyc;
        end
        checks++;
        if (k != 4 || first_valid != 2 || done_cyc != 6) begin
            errors++;
            $display("FAIL stride2_summary: got windows %0d first_valid %0d done %0d want 4 2 6",
                     k, first_valid, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_scan();
        test_alternating();
        test_random();
        test_stride2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
